// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: bus widths, response codes, master FSM states.
package axil_pkg;

    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
    localparam int unsigned AXI_RESP_W = 2;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        WAIT_B = 3'd2,
        READ   = 3'd3,
        WAIT_R = 3'd4,
        RESP   = 3'd5
    } axil_master_state_e;

    // Response payload returned to the command-port client
    typedef struct packed {
        logic [AXI_DATA_W-1:0] rdata;
        logic [AXI_RESP_W-1:0] resp;
        logic                  write;
    } axil_rsp_t;

endpackage

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command port.
module axil_master
    import axil_pkg::*;
#(
    parameter int unsigned AXI_ADDR_BW_p = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_write,
    input  logic [AXI_ADDR_BW_p-1:0] i_req_addr,
    input  logic [AXI_DATA_W-1:0]    i_req_wdata,
    input  logic [AXI_STRB_W-1:0]    i_req_wstrb,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [AXI_DATA_W-1:0]    o_rsp_rdata,
    output logic [AXI_RESP_W-1:0]    o_rsp_resp,
    output logic                     o_rsp_write,
    output logic [AXI_ADDR_BW_p-1:0] o_axi_awaddr,
    output logic                     o_axi_awvalid,
    input  logic                     i_axi_awready,
    output logic [AXI_DATA_W-1:0]    o_axi_wdata,
    output logic [AXI_STRB_W-1:0]    o_axi_wstrb,
    output logic                     o_axi_wvalid,
    input  logic                     i_axi_wready,
    input  logic [AXI_RESP_W-1:0]    i_axi_bresp,
    input  logic                     i_axi_bvalid,
    output logic                     o_axi_bready,
    output logic [AXI_ADDR_BW_p-1:0] o_axi_araddr,
    output logic                     o_axi_arvalid,
    input  logic                     i_axi_arready,
    input  logic [AXI_DATA_W-1:0]    i_axi_rdata,
    input  logic [AXI_RESP_W-1:0]    i_axi_rresp,
    input  logic                     i_axi_rvalid,
    output logic                     o_axi_rready
);

    axil_master_state_e       state_q, state_d;
    logic                     req_ready_q, req_ready_d;
    logic [AXI_ADDR_BW_p-1:0] addr_q, addr_d;
    logic [AXI_DATA_W-1:0]    wdata_q, wdata_d;
    logic [AXI_STRB_W-1:0]    wstrb_q, wstrb_d;
    logic                     awvalid_q, awvalid_d;
    logic                     wvalid_q, wvalid_d;
    logic                     bready_q, bready_d;
    logic                     arvalid_q, arvalid_d;
    logic                     rready_q, rready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    axil_rsp_t                rsp_q, rsp_d;
    logic                     aw_done, w_done;

    // Next-state and next-output decode; every output is a flop fed from here
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        aw_done     = 1'b0;
        w_done      = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                // Ready is registered, so the first cycle out of reset never accepts
                if (i_req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    addr_d      = i_req_addr;
                    wdata_d     = i_req_wdata;
                    wstrb_d     = i_req_wstrb;
                    rsp_d.write = i_req_write;
                    if (i_req_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = READ;
                    end
                end
            end
            WRITE: begin
                // Each channel is finished once its valid is gone or handshakes now
                aw_done = !awvalid_q || i_axi_awready;
                w_done  = !wvalid_q  || i_axi_wready;
                if (awvalid_q && i_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q  && i_axi_wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_axi_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_d.rdata = '0;
                    rsp_d.resp  = i_axi_bresp;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            READ: begin
                if (arvalid_q && i_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = WAIT_R;
                end
            end
            WAIT_R: begin
                if (i_axi_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_d.rdata = i_axi_rdata;
                    rsp_d.resp  = i_axi_rresp;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_q && i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign o_req_ready   = req_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_q.rdata;
    assign o_rsp_resp    = rsp_q.resp;
    assign o_rsp_write   = rsp_q.write;
    assign o_axi_awaddr  = addr_q;
    assign o_axi_awvalid = awvalid_q;
    assign o_axi_wdata   = wdata_q;
    assign o_axi_wstrb   = wstrb_q;
    assign o_axi_wvalid  = wvalid_q;
    assign o_axi_bready  = bready_q;
    assign o_axi_araddr  = addr_q;
    assign o_axi_arvalid = arvalid_q;
    assign o_axi_rready  = rready_q;

endmodule
